// File: rtl/reg_scan.sv
// Register-file scanner: walks FirstAdr..LastAdr (mod 32) and emits each word on a valid/ready port.
// Define REG_SCAN_CHECKSUM_EN to add a running XOR of emitted words on the Checksum output.
module reg_scan #(
   parameter bit SKIP_X0 = 1'b0
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [4:0]  FirstAdr,
   input  logic [4:0]  LastAdr,
   output logic [4:0]  RdAdr,
   input  logic [31:0] RdData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [4:0]  OutAdr,
   output logic [31:0] OutData,
   output logic        Busy,
   output logic        Done
`ifdef REG_SCAN_CHECKSUM_EN
   ,
   output logic [31:0] Checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   logic [4:0]  cur_r;
   logic [4:0]  last_r;
   logic [4:0]  out_adr_r;
   logic [31:0] out_data_r;
   logic        out_valid_r;
   logic        busy_r;
   logic        done_r;

   logic        at_last_s;
   logic        skip_s;
   logic        start_s;
   logic        hs_s;

   assign at_last_s = (cur_r == last_r);
   assign skip_s    = SKIP_X0 && (cur_r == 5'd0);
   assign start_s   = (state_r == IDLE) && Start;
   assign hs_s      = (state_r == OUT) && OutReady;

   // Scan sequencer; the read port follows the current-address register directly.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r     <= IDLE;
         cur_r       <= 5'd0;
         last_r      <= 5'd0;
         out_adr_r   <= 5'd0;
         out_data_r  <= 32'd0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  cur_r   <= FirstAdr;
                  last_r  <= LastAdr;
                  busy_r  <= 1'b1;
                  state_r <= READ;
               end else begin
                  state_r <= IDLE;
               end
            end
            READ: begin
               if (skip_s) begin
                  if (at_last_s) begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     cur_r   <= cur_r + 5'd1;
                     state_r <= READ;
                  end
               end else begin
                  out_data_r  <= RdData;
                  out_adr_r   <= cur_r;
                  out_valid_r <= 1'b1;
                  state_r     <= OUT;
               end
            end
            OUT: begin
               if (hs_s) begin
                  out_valid_r <= 1'b0;
                  if (at_last_s) begin
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     cur_r   <= cur_r + 5'd1;
                     state_r <= READ;
                  end
               end else begin
                  state_r <= OUT;
               end
            end
            DONE: begin
               // Clearing cur keeps RdAdr at zero whenever the scanner is idle.
               cur_r   <= 5'd0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               cur_r       <= 5'd0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign RdAdr    = cur_r;
   assign OutValid = out_valid_r;
   assign OutAdr   = out_adr_r;
   assign OutData  = out_data_r;
   assign Busy     = busy_r;
   assign Done     = done_r;

`ifdef REG_SCAN_CHECKSUM_EN
   logic [31:0] checksum_r;

   // Running XOR of accepted words, restarted whenever a new scan is accepted.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         checksum_r <= 32'd0;
      end else if (start_s) begin
         checksum_r <= 32'd0;
      end else if (hs_s) begin
         checksum_r <= checksum_r ^ out_data_r;
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign Checksum = checksum_r;
`endif

endmodule
